// File: rtl/ysyx_23060124_pipe_ctrl.sv
// rtl/ysyx_23060124_pipe_ctrl.sv - EXU/WBU pipeline control: scoreboard, hazard stall, redirect/flush/halt
module ysyx_23060124_pipe_ctrl #(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  id_rd_addr,
   input  logic        id_wen,
   input  logic        id_csr_wen,
   input  logic        id_csr_rd,
   input  logic        id_ctrl,
   input  logic        wb_retire,
   input  logic        wb_wen,
   input  logic        wb_csr_wen,
   input  logic        wb_brch,
   input  logic        wb_jal,
   input  logic        wb_jalr,
   input  logic        wb_mret,
   input  logic        wb_ecall,
   input  logic        wb_ebreak,
   input  logic [4:0]  wb_rd_addr,
   input  logic [31:0] wb_res,
   input  logic [31:0] wb_pc_next,
   input  logic [31:0] wb_mepc,
   input  logic [31:0] wb_mtvec,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        halt,
   output logic        err
);

   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_WAIT_CTRL = 2'd1,
      S_REDIRECT  = 2'd2,
      S_HALT      = 2'd3
   } state_t;

   localparam logic [2:0] LP_MAX = 3'(MAX_INFLIGHT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_busy;
   logic        r_csr_busy;
   logic [2:0]  r_cnt;
   logic [31:0] r_redirect_pc;
   logic [31:0] w_redirect_pc_nxt;
   logic        r_err;

   logic        w_stall;
   logic        w_fire;
   logic        w_ret_ok;
   logic        w_ctrl_ret;
   logic        w_unused;

   // only bit 0 of the branch result carries the taken decision
   assign w_unused = ^wb_res[31:1];

   // hazard detection looks at registered state only, so a same-cycle retire never releases a stall
   always_comb begin
      w_stall = 1'b0;
      if (r_state != S_RUN)                          w_stall = 1'b1;
      if (r_cnt == LP_MAX)                           w_stall = 1'b1;
      if (id_rs1_used && r_busy[id_rs1_addr])        w_stall = 1'b1;
      if (id_rs2_used && r_busy[id_rs2_addr])        w_stall = 1'b1;
      if (id_wen && r_busy[id_rd_addr])              w_stall = 1'b1;
      if ((id_csr_rd || id_csr_wen) && r_csr_busy)   w_stall = 1'b1;
   end

   assign id_ready   = ~w_stall;
   assign w_fire     = id_valid & id_ready;
   // a retire with nothing in flight is an error and must not disturb any tracking state
   assign w_ret_ok   = wb_retire & (r_cnt != 3'd0);
   assign w_ctrl_ret = wb_brch | wb_jal | wb_jalr | wb_mret | wb_ecall | wb_ebreak;

   // control FSM next state and redirect target selection
   always_comb begin
      w_state_nxt       = r_state;
      w_redirect_pc_nxt = r_redirect_pc;
      case (r_state)
         S_RUN: begin
            if (w_fire && id_ctrl) w_state_nxt = S_WAIT_CTRL;
         end
         S_WAIT_CTRL: begin
            // retires without ctrl flags are older instructions draining ahead of the ctrl one
            if (w_ret_ok && w_ctrl_ret) begin
               if (wb_ebreak) begin
                  w_state_nxt = S_HALT;
               end else if (wb_ecall) begin
                  w_state_nxt       = S_REDIRECT;
                  w_redirect_pc_nxt = wb_mtvec;
               end else if (wb_mret) begin
                  w_state_nxt       = S_REDIRECT;
                  w_redirect_pc_nxt = wb_mepc;
               end else if (wb_jal || wb_jalr || wb_res[0]) begin
                  w_state_nxt       = S_REDIRECT;
                  w_redirect_pc_nxt = wb_pc_next;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_REDIRECT: begin
            w_state_nxt = S_RUN;
         end
         default: begin
            w_state_nxt = S_HALT;
         end
      endcase
   end

   // FSM state and registered redirect target
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= S_RUN;
         r_redirect_pc <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_redirect_pc <= w_redirect_pc_nxt;
      end
   end

   // register scoreboard; x0 is never marked busy
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_busy <= 32'd0;
      end else begin
         if (w_ret_ok && wb_wen) r_busy[wb_rd_addr] <= 1'b0;
         if (w_fire && id_wen && (id_rd_addr != 5'd0)) r_busy[id_rd_addr] <= 1'b1;
      end
   end

   // CSR busy bit; a CSR writer cannot issue while one is outstanding, so set and clear never collide
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_csr_busy <= 1'b0;
      end else if (w_fire && id_csr_wen) begin
         r_csr_busy <= 1'b1;
      end else if (w_ret_ok && wb_csr_wen) begin
         r_csr_busy <= 1'b0;
      end
   end

   // in-flight counter; simultaneous issue and retire cancel out
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt <= 3'd0;
      end else begin
         case ({w_fire, w_ret_ok})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // sticky underflow error
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (wb_retire && (r_cnt == 3'd0)) begin
         r_err <= 1'b1;
      end
   end

   assign redirect_valid = (r_state == S_REDIRECT);
   assign flush          = (r_state == S_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign halt           = (r_state == S_HALT);
   assign err            = r_err;

endmodule
